expr_vector_sequencer: RTL and testbench

EXPR_VECTOR_SEQUENCER -- requirements
Module: expr_vector_sequencer

---
 rtl/expr_seq_pkg.sv | 46 ++++
 rtl/expr_seq_misr.sv | 42 ++++
 rtl/expr_vector_sequencer.sv | 164 ++++++++++++++++
 tb/tb_expr_vector_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_seq_pkg.sv
// -----------------------------------------------------------------------------
// expr_seq_pkg
// Shared types and constants for the expression vector sequencer:
//   - FSM state enum
//   - operand / result / signature widths and operand group widths
//   - LFSR feedback mask and MISR polynomial, signature init value
//   - lfsr_step(): one Galois step of the operand generator
// -----------------------------------------------------------------------------
package expr_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int OPND_W = 60;
  localparam int RES_W  = 90;
  localparam int SIG_W  = 32;
  localparam int LFSR_W = 64;

  // Operand group widths, a0..a5 then b0..b5 (same pattern for both halves)
  localparam int GRP0_W = 4;
  localparam int GRP1_W = 5;
  localparam int GRP2_W = 6;
  localparam int GRP3_W = 4;
  localparam int GRP4_W = 5;
  localparam int GRP5_W = 6;

  // x^64 + x^63 + x^61 + x^60 + 1, right-shifting Galois form:
  // term x^k maps to feedback bit k-1.
  localparam logic [LFSR_W-1:0] LFSR_POLY = 64'hD800_0000_0000_0000;
  localparam logic [LFSR_W-1:0] LFSR_INIT = 64'h1;

  localparam logic [SIG_W-1:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [SIG_W-1:0] SIG_INIT  = 32'hFFFF_FFFF;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] nxt;
    nxt = s >> 1;
    if (s[0]) nxt = nxt ^ LFSR_POLY;
    return nxt;
  endfunction

endpackage

// File: rtl/expr_seq_misr.sv
// -----------------------------------------------------------------------------
// expr_seq_misr
// 32-bit MISR that folds a 90-bit datapath result into the running signature.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset (signature -> SIG_INIT)
//   i_init  : synchronous re-initialise to SIG_INIT (start of a run)
//   i_en    : absorb i_res this cycle
//   i_res   : datapath result y
//   o_sig   : current signature
// -----------------------------------------------------------------------------
module expr_seq_misr
  import expr_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_init,
  input  logic             i_en,
  input  logic [RES_W-1:0] i_res,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_shift;
  logic [SIG_W-1:0] w_fold;

  // Shift with polynomial feedback, then XOR in the result folded to 32 bits
  // (upper 26 result bits are zero-extended).
  assign w_shift = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? MISR_POLY : '0);
  assign w_fold  = i_res[31:0] ^ i_res[63:32] ^ {6'b0, i_res[89:64]};

  always_ff @(posedge clk) begin
    if (rst || i_init) begin
      r_sig <= SIG_INIT;
    end else if (i_en) begin
      r_sig <= w_shift ^ w_fold;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/expr_vector_sequencer.sv
// -----------------------------------------------------------------------------
// expr_vector_sequencer
// Issues LFSR-generated operand vectors to an expression datapath and
// compacts the returned results into a MISR signature.
// Parameters:
//   CNT_W   : width of the vector count (max run 2^CNT_W-1 vectors)
//   RES_LAT : cycles from operand issue to result sample (0..3)
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : begin a run (IDLE/DONE only), cancel active run
//   seed, num_vec     : LFSR seed and run length, sampled on accepted start
//   opnd, opnd_valid  : operand vector to the datapath and its valid
//   res               : datapath result
//   busy, done        : RUN/DRAIN indicator, DONE indicator
//   signature         : MISR value
//   vec_cnt           : vectors issued in the current or last run
// Optional build macro EXPR_SEQ_COMPARE_EN adds:
//   exp_sig (in)      : expected signature, sampled on accepted start
//   pass (out)        : high in DONE when signature == exp_sig
// -----------------------------------------------------------------------------
module expr_vector_sequencer
  import expr_seq_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int RES_LAT = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [63:0]       seed,
  input  logic [CNT_W-1:0]  num_vec,
  output logic [OPND_W-1:0] opnd,
  output logic              opnd_valid,
  input  logic [RES_W-1:0]  res,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  vec_cnt
`ifdef EXPR_SEQ_COMPARE_EN
  ,
  input  logic [SIG_W-1:0]  exp_sig,
  output logic              pass
`endif
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [CNT_W-1:0]    r_vec_cnt;
  logic [CNT_W-1:0]    r_num;
  logic [OPND_W-1:0]   r_opnd_hold;
  logic                w_load;
  logic                w_busy;
  logic                w_abort;
  logic                w_issue;
  logic                w_last;
  logic                w_absorb;
  logic                w_drain_empty;

  assign w_busy  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_abort = abort && w_busy;
  // An aborting RUN cycle does not count as an issue: counters stay put.
  assign w_issue = (r_state == ST_RUN) && !abort;
  assign w_last  = (r_vec_cnt == (r_num - CNT_W'(1)));

  // In-flight tracking: one valid bit per pipeline stage of the datapath
  if (RES_LAT == 0) begin : g_lat0
    assign w_absorb      = w_issue;
    assign w_drain_empty = 1'b1;
  end else begin : g_line
    logic [RES_LAT-1:0] r_vld;

    always_ff @(posedge clk) begin
      if (rst || w_abort) begin
        r_vld <= '0;
      end else begin
        r_vld <= (r_vld << 1) | RES_LAT'(w_issue);
      end
    end

    assign w_absorb      = r_vld[RES_LAT-1] && !w_abort;
    // Empty once only the oldest entry (absorbed this cycle) remains
    assign w_drain_empty = ((r_vld << 1) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (num_vec == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = (RES_LAT == 0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort)              w_state_nxt = ST_IDLE;
        else if (w_drain_empty) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr    <= LFSR_INIT;
      r_vec_cnt <= '0;
      r_num     <= '0;
    end else if (w_load) begin
      r_lfsr    <= (seed == '0) ? LFSR_INIT : seed;
      r_vec_cnt <= '0;
      r_num     <= num_vec;
    end else if (w_issue) begin
      r_lfsr    <= lfsr_step(r_lfsr);
      r_vec_cnt <= r_vec_cnt + CNT_W'(1);
    end
  end

  // Keeps the last driven operand visible once RUN is left
  always_ff @(posedge clk) begin
    if (rst)                     r_opnd_hold <= '0;
    else if (r_state == ST_RUN)  r_opnd_hold <= r_lfsr[OPND_W-1:0];
  end

  expr_seq_misr u_misr (
    .clk    (clk),
    .rst    (rst),
    .i_init (w_load),
    .i_en   (w_absorb),
    .i_res  (res),
    .o_sig  (signature)
  );

  assign opnd       = (r_state == ST_RUN) ? r_lfsr[OPND_W-1:0] : r_opnd_hold;
  assign opnd_valid = (r_state == ST_RUN);
  assign busy       = w_busy;
  assign done       = (r_state == ST_DONE);
  assign vec_cnt    = r_vec_cnt;

`ifdef EXPR_SEQ_COMPARE_EN
  logic [SIG_W-1:0] r_exp_sig;

  always_ff @(posedge clk) begin
    if (rst)         r_exp_sig <= '0;
    else if (w_load) r_exp_sig <= exp_sig;
  end

  assign pass = (r_state == ST_DONE) && (signature == r_exp_sig);
`endif

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// -----------------------------------------------------------------------------
// tb_expr_vector_sequencer
// Table-driven runs plus hand-written abort / reset / start-while-busy
// sequences. Expected operands and signatures come from a reference model
// that steps the polynomial-defined LFSR and MISR over whole runs.
// -----------------------------------------------------------------------------
module tb_expr_vector_sequencer;

  localparam int CNT_W   = 16;
  localparam int RES_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [63:0]       seed;
  logic [CNT_W-1:0]  num_vec;
  logic [59:0]       opnd;
  logic              opnd_valid;
  logic [89:0]       res;
  logic              busy;
  logic              done;
  logic [31:0]       signature;
  logic [CNT_W-1:0]  vec_cnt;
`ifdef EXPR_SEQ_COMPARE_EN
  logic [31:0]       exp_sig;
  logic              pass;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit res_mode = 1'b0;
  bit cmp_flip = 1'b0;

  expr_vector_sequencer #(.CNT_W(CNT_W), .RES_LAT(RES_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .seed       (seed),
    .num_vec    (num_vec),
    .opnd       (opnd),
    .opnd_valid (opnd_valid),
    .res        (res),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .vec_cnt    (vec_cnt)
`ifdef EXPR_SEQ_COMPARE_EN
    ,
    .exp_sig    (exp_sig),
    .pass       (pass)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [89:0] dp(input logic [59:0] v);
    logic [59:0] p;
    p = 60'(v[59:30]) * 60'(v[29:0]);
    return {p, v[59:30] ^ v[29:0]};
  endfunction

  // Attached datapath with one cycle of latency (RES_LAT = 1)
  always @(posedge clk) res <= res_mode ? dp(opnd) : 90'd0;

  function automatic logic [63:0] lfsr_ref(input logic [63:0] s);
    logic [63:0] taps;
    taps = '0;
    taps[63] = 1'b1;  // x^64
    taps[62] = 1'b1;  // x^63
    taps[60] = 1'b1;  // x^61
    taps[59] = 1'b1;  // x^60
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

  function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [89:0] y);
    logic [32:0] t;
    t = {1'b0, s} << 1;
    if (t[32]) t[31:0] = t[31:0] ^ 32'h04C11DB7;
    return t[31:0] ^ y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] seed;
    int          nv;
    bit          mode;
    int          start_at;
    bit          use_const;
    logic [31:0] sig_const;
  } vec_t;

  task automatic do_entry(input vec_t e);
    logic [59:0] q[$];
    logic [63:0] l;
    logic [31:0] s;
    logic [31:0] exp;
    int cyc;
    int nval;
    l = (e.seed == 64'd0) ? 64'h1 : e.seed;
    s = 32'hFFFFFFFF;
    for (int i = 0; i < e.nv; i++) begin
      q.push_back(l[59:0]);
      s = misr_ref(s, e.mode ? dp(l[59:0]) : 90'd0);
      l = lfsr_ref(l);
    end
    exp = e.use_const ? e.sig_const : s;
`ifdef EXPR_SEQ_COMPARE_EN
    exp_sig = s ^ {31'b0, cmp_flip};
`endif
    res_mode = e.mode;
    seed     = e.seed;
    num_vec  = 16'(e.nv);
    start    = 1'b1;
    cyc  = 0;
    nval = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (e.start_at > 0 && cyc == e.start_at) begin
        start   = 1'b1;
        seed    = ~e.seed;
        num_vec = 16'd3;
      end
      if (opnd_valid) begin
        if (nval < q.size()) chk("opnd", opnd, q[nval]);
        nval++;
      end
    end while (!done && cyc < e.nv + 20);
    chk("done_reached", done, 1);
    chk("done_latency", cyc, (e.nv == 0) ? 1 : e.nv + 1 + RES_LAT);
    chk("valid_cycles", nval, e.nv);
    chk("vec_cnt", vec_cnt, e.nv);
    chk("signature", signature, exp);
`ifdef EXPR_SEQ_COMPARE_EN
    chk("pass", pass, !cmp_flip);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t e;
    logic [63:0] l;
    logic [31:0] s;
    int k;

    rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; num_vec = '0;
`ifdef EXPR_SEQ_COMPARE_EN
    exp_sig = '0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_opnd_valid", opnd_valid, 0);
    chk("rst_opnd", opnd, 0);
    chk("rst_signature", signature, 32'hFFFFFFFF);
    chk("rst_vec_cnt", vec_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    tbl[0] = '{seed: {$urandom, $urandom}, nv: 0,   mode: 1, start_at: 0,  use_const: 1, sig_const: 32'hFFFFFFFF};
    tbl[1] = '{seed: 64'd0,                nv: 1,   mode: 0, start_at: 0,  use_const: 1, sig_const: 32'hFB3EE249};
    tbl[2] = '{seed: {$urandom, $urandom}, nv: 100, mode: 1, start_at: 0,  use_const: 0, sig_const: 32'h0};
    tbl[3] = '{seed: 64'hFFFF_FFFF_FFFF_FFFF, nv: 7, mode: 1, start_at: 0, use_const: 0, sig_const: 32'h0};
    tbl[4] = '{seed: {$urandom, $urandom}, nv: 40,  mode: 1, start_at: 10, use_const: 0, sig_const: 32'h0};
    tbl[5] = '{seed: {$urandom, $urandom}, nv: int'($urandom_range(2, 40)), mode: 1, start_at: 0, use_const: 0, sig_const: 32'h0};
    tbl[6] = '{seed: 64'h1, nv: 1, mode: 0, start_at: 0, use_const: 1, sig_const: 32'hFB3EE249};

    for (int i = 0; i < 7; i++) do_entry(tbl[i]);

    // Abort at vector 10 of 50: the absorb due this cycle is dropped
    seed = {$urandom, $urandom};
    l = (seed == 64'd0) ? 64'h1 : seed;
    s = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      s = misr_ref(s, dp(l[59:0]));
      l = lfsr_ref(l);
    end
    res_mode = 1'b1; num_vec = 16'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (vec_cnt != 16'd10 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach_10", vec_cnt, 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_vec_cnt", vec_cnt, 10);
    chk("abort_signature", signature, s);
    repeat (3) @(negedge clk);
    chk("abort_sig_hold", signature, s);
    chk("abort_valid_low", opnd_valid, 0);
    e = '{seed: {$urandom, $urandom}, nv: 25, mode: 1, start_at: 0, use_const: 0, sig_const: 32'h0};
    do_entry(e);

    // Reset while draining
    res_mode = 1'b1; seed = {$urandom, $urandom}; num_vec = 16'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(busy && !opnd_valid) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("drain_reached", busy && !opnd_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("drain_rst_busy", busy, 0);
    chk("drain_rst_done", done, 0);
    chk("drain_rst_valid", opnd_valid, 0);
    chk("drain_rst_opnd", opnd, 0);
    chk("drain_rst_signature", signature, 32'hFFFFFFFF);
    chk("drain_rst_vec_cnt", vec_cnt, 0);
    e = '{seed: 64'd0, nv: 3, mode: 1, start_at: 0, use_const: 0, sig_const: 32'h0};
    do_entry(e);

`ifdef EXPR_SEQ_COMPARE_EN
    cmp_flip = 1'b0;
    e = '{seed: {$urandom, $urandom}, nv: 12, mode: 1, start_at: 0, use_const: 0, sig_const: 32'h0};
    do_entry(e);
    cmp_flip = 1'b1;
    do_entry(e);
    cmp_flip = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
